// File: rtl/wide_unpack_tx.sv
// ---------------------------------------------------------------------------
// wide_unpack_tx
//
// Transmit side of the wide eFPGA data path. One WIDTH-bit word is taken in
// over a valid/ready handshake and sent out as BEATS narrow OUT_W-bit beats,
// least significant slice first, over a second valid/ready handshake toward
// the 32-bit user bus. When the downstream side keeps accepting, a new word
// is taken in the same cycle as the last beat of the previous word leaves,
// so consecutive words stream out with no idle cycles between them.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream word on in_data is valid
//   in_ready   block can take a word this cycle (0 while rst is high)
//   in_data    WIDTH-bit word to transmit
//   out_valid  out_data holds a beat
//   out_ready  downstream takes the beat this cycle
//   out_data   current OUT_W-bit beat
//   out_idx    index of the current beat within its word, 0..BEATS-1
//   out_last   current beat is the final beat of its word
//   busy       a word is being held and sent
// ---------------------------------------------------------------------------
module wide_unpack_tx #(
    parameter int WIDTH = 128,
    parameter int OUT_W = 32,
    parameter int BEATS = WIDTH / OUT_W,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    // Two-state controller: waiting for a word, or sending one.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;

    logic in_fire;
    logic beat_fire;

    // The outputs come straight from state: out_valid and busy are the SEND
    // flag, and the beat is the low slice of the hold register. The hold
    // register is shifted down after each beat, so the next slice is always
    // sitting at the bottom and no output mux is needed.
    assign out_valid = (state == ST_SEND);
    assign busy      = (state == ST_SEND);
    assign out_data  = hold[OUT_W-1:0];
    assign out_idx   = idx;
    assign out_last  = out_valid & (idx == LAST_IDX);

    // A word can be taken while idle, or in the very cycle the last beat of
    // the current word is being accepted. That second term makes in_ready
    // depend combinationally on out_ready, which is what lets words stream
    // back to back. Reset forces in_ready low so nothing is taken while the
    // block is being cleared.
    assign in_ready  = ~rst & ((state == ST_IDLE) | (out_valid & out_ready & out_last));

    assign in_fire   = in_valid & in_ready;
    assign beat_fire = out_valid & out_ready;

    // Next-state logic. Everything holds by default, which covers the stall
    // case (beat offered but not accepted) and the case where in_valid is
    // raised mid-word: the upstream source must keep its word until it is
    // taken. A non-last beat shifts the hold register down one slice and
    // advances the index. After the last beat the index returns to 0 and
    // either the next word is loaded or the block drops back to idle with a
    // cleared register.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (in_fire) begin
                    hold_nxt  = in_data;
                    idx_nxt   = '0;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_fire) begin
                    if (out_last) begin
                        idx_nxt = '0;
                        if (in_fire) begin
                            hold_nxt  = in_data;
                            state_nxt = ST_SEND;
                        end else begin
                            hold_nxt  = '0;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        hold_nxt = hold >> OUT_W;
                        idx_nxt  = idx + IDX_ONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                hold_nxt  = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // State registers. Reset clears everything asynchronously, so a word in
    // flight is dropped immediately and out_valid falls without waiting for
    // a clock edge; nothing of the old word survives into the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            hold  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            idx   <= idx_nxt;
        end
    end

endmodule
